// File: rtl/zprize_mul_split.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zprize_mul_split                                             |
// | Description : Limb-split pipelined unsigned multiplier with valid/ready    |
// |               handshake and aligned sideband. Optional handshake counter   |
// |               output dbg_cnt is enabled by macro ZPRIZE_MUL_SPLIT_DBG_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module zprize_mul_split #(
   parameter int W0   = 48,
   parameter int W1   = 48,
   parameter int LIMB = 26,
   parameter int M    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W0-1:0]     in0,
   input  logic [W1-1:0]     in1,
   input  logic [M-1:0]      m_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W0+W1-1:0]  out0,
   output logic [M-1:0]      m_o
`ifdef ZPRIZE_MUL_SPLIT_DBG_EN
   ,
   output logic [31:0]       dbg_cnt
`endif
);

   localparam int NLIMB = (W0 + LIMB - 1) / LIMB;
   localparam int WP    = W0 + W1;
   localparam int WA    = NLIMB * LIMB;

   logic              r_rdy;
   logic              w_adv;
   logic              w_acc;

   logic              r_v0;
   logic [W0-1:0]     r_a;
   logic [W1-1:0]     r_b;
   logic [M-1:0]      r_m0;

   logic [WA-1:0]     w_a_pad;
   logic [WP-1:0]     w_pp  [NLIMB];

   // Stage index 0 is the partial-product stage; index s>0 has summed s+1 terms.
   logic              r_v   [NLIMB];
   logic [M-1:0]      r_m   [NLIMB];
   logic [WP-1:0]     r_acc [NLIMB];
   logic [WP-1:0]     r_pp  [NLIMB][NLIMB];

   logic              r_vo;
   logic [WP-1:0]     r_out;
   logic [M-1:0]      r_mo;

   // One global enable: any downstream stall freezes the whole pipe.
   assign w_adv    = !(r_vo && !out_ready);
   assign in_ready = r_rdy && w_adv;
   assign w_acc    = in_valid && in_ready;
   assign w_a_pad  = WA'(r_a);

   always_comb begin
      for (int k = 0; k < NLIMB; k++) begin
         w_pp[k] = (WP'(w_a_pad[k*LIMB +: LIMB]) * WP'(r_b)) << (k * LIMB);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy <= 1'b0;
         r_v0  <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_m0  <= '0;
         for (int s = 0; s < NLIMB; s++) begin
            r_v[s]   <= 1'b0;
            r_m[s]   <= '0;
            r_acc[s] <= '0;
            for (int k = 0; k < NLIMB; k++) begin
               r_pp[s][k] <= '0;
            end
         end
         r_vo  <= 1'b0;
         r_out <= '0;
         r_mo  <= '0;
      end else begin
         r_rdy <= 1'b1;
         if (w_adv) begin
            r_v0     <= w_acc;
            r_a      <= in0;
            r_b      <= in1;
            r_m0     <= m_i;
            r_v[0]   <= r_v0;
            r_m[0]   <= r_m0;
            r_acc[0] <= w_pp[0];
            for (int k = 0; k < NLIMB; k++) begin
               r_pp[0][k] <= w_pp[k];
            end
            for (int s = 1; s < NLIMB; s++) begin
               r_v[s]   <= r_v[s-1];
               r_m[s]   <= r_m[s-1];
               r_acc[s] <= r_acc[s-1] + r_pp[s-1][s];
               for (int k = 0; k < NLIMB; k++) begin
                  r_pp[s][k] <= r_pp[s-1][k];
               end
            end
            r_vo  <= r_v[NLIMB-1];
            r_out <= r_acc[NLIMB-1];
            r_mo  <= r_m[NLIMB-1];
         end
      end
   end

   assign out_valid = r_vo;
   assign out0      = r_out;
   assign m_o       = r_mo;

`ifdef ZPRIZE_MUL_SPLIT_DBG_EN
   logic [31:0] r_dbg_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbg_cnt <= '0;
      end else if (r_vo && out_ready) begin
         r_dbg_cnt <= r_dbg_cnt + 32'd1;
      end
   end

   assign dbg_cnt = r_dbg_cnt;
`endif

endmodule
`default_nettype wire
